data_mem_ctrl: RTL
==================

# data_mem_ctrl

Data-memory controller sitting directly downstream of the pipelined core's memory stage. Accepts the core's data request (byte address, store data, byte mask, write/read select), performs the access on an internal word-organised RAM after a fixed number of wait cycles, and returns a single-cycle `valid` pulse with read data. The data path is `load_data` → core `load_data_in`, and the handshake is `valid` → core `data_mem_valid`.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: word-address bits; RAM depth is 2^ADDR_WIDTH words of 32 bits.
- `LATENCY`, default 1: wait cycles from request acceptance to response. Legal range is 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `request`  in  1  access request from the core.
- `we_re`  in  1  1 = write (store), 0 = read (load).
- `mask`  in  4  byte enables; bit i covers bits [8i+7:8i].
- `address`  in  32  byte address. Word index is `address[ADDR_WIDTH+1:2]`.
- `store_data`  in  32  write data, already lane-aligned by the core.
- `valid`  out  1  one-cycle completion pulse, for reads and writes.
- `load_data`  out  32  full read word. It holds its value until the next read completes.
- `busy`  out  1  high while an access is in flight (state WAIT).

## Operation
- FSM states are IDLE, WAIT and RESP. All registers are reset asynchronously.
- **IDLE:**
  - `request` is sampled on each rising edge.
  - If it is high, latch `we_re`, `mask`, word index and `store_data`.
  - Load counter with `LATENCY` and go to WAIT.
- **WAIT:**
  - Decrement the counter on each edge. `request` is ignored.
  - On the edge where counter == 1, perform the access and go to RESP.
  - For a write, each byte i of RAM[index] is updated where latched mask[i]=1; other bytes keep their value.
  - For a read, `load_data` ← RAM[index], full word; mask is ignored.
- **RESP:**
  - `valid`=1 for exactly this cycle. The next edge always returns to IDLE, and `request` is not sampled in RESP.
  - The requester holds `request` until it sees `valid` and must drop it in the `valid` cycle. A request still high in the following IDLE cycle is taken as a new access.
- `address[1:0]` is ignored. Address bits above `ADDR_WIDTH+1` are ignored, so the address aliases (see Configuration).
- A write leaves `load_data` unchanged.
- Mask 4'b0000 on a write gives no RAM change, but `valid` still pulses.
- RAM contents are not reset and are undefined until written. A `ifdef`-free `$readmemh` hook is not part of this block.

## Timing
- Reset values: `valid`=0, `busy`=0, `load_data`=32'h0, state=IDLE, counter=0.
- Request sampled at edge E0 → `busy` high from E0 to E(LATENCY) → `valid` high from E(LATENCY) to E(LATENCY+1).
- With LATENCY=1: valid is high in the cycle after acceptance, and `busy` is high for 1 cycle.
- Read data is valid on `load_data` in the same cycle as `valid` and stays valid afterwards.
- Back-to-back throughput is one access per LATENCY+2 cycles (IDLE, WAIT×LATENCY, RESP).
- `rst` asserted mid-access: the FSM goes to IDLE immediately and `valid`/`busy` drop asynchronously. A pending write that has not yet been performed is discarded, and a write already performed stays in RAM.
- Outputs are registered only; there is no combinational path from inputs to `valid` or `load_data`.

## Configuration
- Macro `DMEM_BOUNDS_CHECK_EN`.
- **Defined:**
  - Adds output port `err` (1 bit, reset 0).
  - An access whose `address[31:ADDR_WIDTH+2]` is non-zero is out of range.
  - For an out-of-range access, the write is suppressed and a read returns `load_data`=32'h0.
  - `err`=1 during that access's `valid` cycle and 0 otherwise.
- **Undefined:** there is no `err` port and upper address bits alias.

## Test plan
- Reset then idle: `rst`=1 for 3 cycles → `valid`=0, `busy`=0, `load_data`=0. Hold `request`=0 for 10 cycles → `valid` stays 0.
- Full write/read, LATENCY=1: write 32'hDEADBEEF to 0x40 with mask 4'hF. Read 0x40 → `valid` 1 cycle after each acceptance and `load_data`=32'hDEADBEEF.
- Byte mask: after the previous test, write 32'h00AA0000 to 0x40 with mask 4'b0100, then read → 32'hDEAABEEF. Writing with mask 4'b0000 leaves the word unchanged.
- Latency/back-to-back, LATENCY=4: issue two reads back-to-back, requester drops `request` on `valid` → `busy` high for 4 cycles each, `valid` at E4 and E10, no third access.
- Reset mid-access, LATENCY=4: write 32'h12345678 to 0x80, assert `rst` at E2 → `valid` never pulses. A subsequent read of 0x80 returns the old contents.
- With `DMEM_BOUNDS_CHECK_EN`, ADDR_WIDTH=10: write to 0x1000 → `err`=1 with `valid` and RAM[0] unchanged. Read 0x1000 → `load_data`=0 and `err`=1. Read 0x0 → `err`=0.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: fixed-latency access to a word-organised RAM with byte-lane writes.
// Optional `DMEM_BOUNDS_CHECK_EN adds an err output and suppresses accesses above the RAM range.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request,
  input  logic        we_re,
  input  logic [3:0]  mask,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        valid,
  output logic [31:0] load_data,
  output logic        busy
`ifdef DMEM_BOUNDS_CHECK_EN
  ,
  output logic        err
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              count_reg, count_next;
  logic                    we_reg;
  logic [3:0]              mask_reg;
  logic [ADDR_WIDTH-1:0]   index_reg;
  logic [31:0]             data_reg;
  logic                    oor_reg;
  logic                    accept;
  logic                    access;
  logic                    do_write;
  logic                    do_read;
  logic [3:0][7:0]         lane_data;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^{address[1:0], address[31:ADDR_WIDTH+2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (request) begin
          state_next = WAIT;
          count_next = 4'(LATENCY);
        end
      end
      WAIT: begin
        count_next = count_reg - 4'd1;
        if (count_reg == 4'd1) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign accept   = (state_reg == IDLE) && request;
  assign access   = (state_reg == WAIT) && (count_reg == 4'd1);
  // Gate the RAM write with rst so a reset coinciding with the access edge discards it.
  assign do_write = access && we_reg && !oor_reg && !rst;
  assign do_read  = access && !we_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_reg    <= 1'b0;
      mask_reg  <= 4'h0;
      index_reg <= '0;
      data_reg  <= 32'h0;
    end else if (accept) begin
      we_reg    <= we_re;
      mask_reg  <= mask;
      index_reg <= address[ADDR_WIDTH+1:2];
      data_reg  <= store_data;
    end
  end

`ifdef DMEM_BOUNDS_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oor_reg <= 1'b0;
    end else if (accept) begin
      oor_reg <= |address[31:ADDR_WIDTH+2];
    end
  end

  assign err = (state_reg == RESP) && oor_reg;
`else
  assign oor_reg = 1'b0;
`endif

  // One byte-wide RAM per lane so each lane's write enable maps to its own array.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] ram_lane [DEPTH];
    logic [7:0] rd_byte;

    always_ff @(posedge clk) begin
      if (do_write && mask_reg[gi]) begin
        ram_lane[index_reg] <= data_reg[8*gi +: 8];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_byte <= 8'h0;
      end else if (do_read) begin
        rd_byte <= oor_reg ? 8'h0 : ram_lane[index_reg];
      end
    end

    assign lane_data[gi] = rd_byte;
  end

  assign load_data = lane_data;
  assign valid     = (state_reg == RESP);
  assign busy      = (state_reg == WAIT);

endmodule
